// File: rtl/cnn_stream_pkg.sv
//------------------------------------------------------------------------------
// Module  : cnn_stream_pkg
// Brief   : Shared types and helpers for parallel <-> stream CNN adapters.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cnn_stream_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } stream_state_t;

    // Effective vector length: requested count limited to buffer capacity.
    function automatic logic [31:0] clamp_len(input logic [31:0] count,
                                              input logic [31:0] max_elems);
        return (count > max_elems) ? max_elems : count;
    endfunction

    // LSB position of element 'index' inside a flat vector.
    function automatic int unsigned elem_lsb(input int unsigned index,
                                             input int unsigned width);
        return index * width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/stream_elem_mux.sv
//------------------------------------------------------------------------------
// Module  : stream_elem_mux
// Brief   : Combinational select of one element from a flat vector.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module stream_elem_mux
    import cnn_stream_pkg::*;
#(
    parameter int ELEM_WIDTH = 8,
    parameter int NUM_ELEMS  = 1024,
    parameter int CNT_WIDTH  = $clog2(NUM_ELEMS + 1)
) (
    input  logic [NUM_ELEMS*ELEM_WIDTH-1:0] vec,
    input  logic [CNT_WIDTH-1:0]            index,
    output logic [ELEM_WIDTH-1:0]           elem
);

    localparam int IDX_W = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;

    logic [ELEM_WIDTH-1:0] w_elems [NUM_ELEMS];

    generate
        for (genvar gi = 0; gi < NUM_ELEMS; gi++) begin : g_unpack
            assign w_elems[gi] = vec[elem_lsb(gi, ELEM_WIDTH) +: ELEM_WIDTH];
        end
    endgenerate

    // Out-of-range indices read as zero rather than aliasing a real element.
    always_comb begin
        elem = '0;
        if (index < CNT_WIDTH'(NUM_ELEMS)) begin
            elem = w_elems[index[IDX_W-1:0]];
        end
    end

endmodule

`default_nettype wire

// File: rtl/layer_output_streamer.sv
//------------------------------------------------------------------------------
// Module  : layer_output_streamer
// Brief   : Captures a flat layer result vector and replays it as a stream.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module layer_output_streamer
    import cnn_stream_pkg::*;
#(
    parameter int ELEM_WIDTH = 8,
    parameter int NUM_ELEMS  = 1024,
    parameter int CNT_WIDTH  = $clog2(NUM_ELEMS + 1)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            valid_in,
    input  logic [NUM_ELEMS*ELEM_WIDTH-1:0] data_in,
    input  logic [31:0]                     elem_count,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [ELEM_WIDTH-1:0]           m_data,
    output logic                            m_last,
    output logic                            busy,
    output logic                            overrun
);

    stream_state_t r_state, w_state_nxt;

    logic [NUM_ELEMS*ELEM_WIDTH-1:0] r_buf;
    logic [CNT_WIDTH-1:0]            r_len, r_index;
    logic [CNT_WIDTH-1:0]            w_len_nxt, w_index_nxt, w_len_in, w_idx_inc;
    logic [ELEM_WIDTH-1:0]           w_data_nxt, w_mux_elem;
    logic                            w_valid_nxt, w_last_nxt, w_overrun_nxt;
    logic                            w_capture, w_cap_req, w_xfer;

    assign w_xfer    = m_valid && m_ready;
    assign w_cap_req = valid_in && (elem_count != 32'd0);
    assign w_len_in  = CNT_WIDTH'(clamp_len(elem_count, 32'(NUM_ELEMS)));
    assign w_idx_inc = r_index + CNT_WIDTH'(1);
    assign busy      = (r_state == STREAM);

    stream_elem_mux #(
        .ELEM_WIDTH (ELEM_WIDTH),
        .NUM_ELEMS  (NUM_ELEMS),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_elem_mux (
        .vec   (r_buf),
        .index (w_idx_inc),
        .elem  (w_mux_elem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_valid_nxt   = m_valid;
        w_data_nxt    = m_data;
        w_last_nxt    = m_last;
        w_index_nxt   = r_index;
        w_len_nxt     = r_len;
        w_overrun_nxt = overrun;
        w_capture     = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_cap_req) begin
                    w_capture = 1'b1;
                end
            end
            STREAM: begin
                if (w_xfer && m_last) begin
                    // A new vector arriving with the final beat chains on without a bubble.
                    if (w_cap_req) begin
                        w_capture = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                    end
                end else begin
                    if (w_cap_req) begin
                        w_overrun_nxt = 1'b1;
                    end
                    if (w_xfer) begin
                        w_index_nxt = w_idx_inc;
                        w_data_nxt  = w_mux_elem;
                        w_last_nxt  = (w_idx_inc == r_len - CNT_WIDTH'(1));
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_valid_nxt = 1'b0;
                w_last_nxt  = 1'b0;
            end
        endcase

        // Element 0 comes straight from data_in since the buffer loads on this same edge.
        if (w_capture) begin
            w_state_nxt = STREAM;
            w_valid_nxt = 1'b1;
            w_data_nxt  = data_in[ELEM_WIDTH-1:0];
            w_last_nxt  = (w_len_in == CNT_WIDTH'(1));
            w_index_nxt = '0;
            w_len_nxt   = w_len_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
            overrun <= 1'b0;
            r_index <= '0;
            r_len   <= '0;
        end else begin
            m_valid <= w_valid_nxt;
            m_data  <= w_data_nxt;
            m_last  <= w_last_nxt;
            overrun <= w_overrun_nxt;
            r_index <= w_index_nxt;
            r_len   <= w_len_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_buf <= data_in;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_layer_output_streamer.sv
//------------------------------------------------------------------------------
// Module  : tb_layer_output_streamer
// Brief   : Self-checking bench for layer_output_streamer against a beat-queue model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_layer_output_streamer;

    localparam int EW = 8;
    localparam int NE = 16;
    localparam int CW = $clog2(NE + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              valid_in = 1'b0;
    logic [NE*EW-1:0]  data_in = '0;
    logic [31:0]       elem_count = '0;
    logic              m_ready = 1'b0;
    logic              m_valid;
    logic [EW-1:0]     m_data;
    logic              m_last;
    logic              busy;
    logic              overrun;

    always #5 clk = ~clk;

    layer_output_streamer #(
        .ELEM_WIDTH (EW),
        .NUM_ELEMS  (NE),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .elem_count (elem_count),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy),
        .overrun    (overrun)
    );

    typedef struct {
        logic [EW-1:0] data;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    logic  exp_ovr = 1'b0;
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, check outputs against model, advance model.
    task automatic cycle(input logic vin, input logic [NE*EW-1:0] vec,
                         input logic [31:0] cnt, input logic rdy);
        logic  exp_valid;
        int    len;
        beat_t b;
        valid_in   = vin;
        data_in    = vec;
        elem_count = cnt;
        m_ready    = rdy;
        exp_valid  = (exp_q.size() > 0);
        chk("m_valid", 32'(m_valid), 32'(exp_valid));
        chk("busy", 32'(busy), 32'(exp_valid));
        chk("overrun", 32'(overrun), 32'(exp_ovr));
        if (exp_valid) begin
            chk("m_data", 32'(m_data), 32'(exp_q[0].data));
            chk("m_last", 32'(m_last), 32'(exp_q[0].last));
            if (rdy) void'(exp_q.pop_front());
        end
        if (vin && cnt != 0) begin
            if (exp_q.size() == 0) begin
                len = (cnt > NE) ? NE : int'(cnt);
                for (int i = 0; i < len; i++) begin
                    b.data = vec[i*EW +: EW];
                    b.last = (i == len - 1);
                    exp_q.push_back(b);
                end
            end else begin
                exp_ovr = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, '0, 32'd0, 1'b1);
    endtask

    function automatic logic [NE*EW-1:0] vec4(input logic [7:0] b0, input logic [7:0] b1,
                                              input logic [7:0] b2, input logic [7:0] b3);
        logic [NE*EW-1:0] v;
        v = '0;
        v[7:0]   = b0;
        v[15:8]  = b1;
        v[23:16] = b2;
        v[31:24] = b3;
        return v;
    endfunction

    function automatic logic [NE*EW-1:0] rand_vec();
        logic [NE*EW-1:0] v;
        for (int i = 0; i < NE; i++) v[i*EW +: EW] = EW'($urandom);
        return v;
    endfunction

    int bp[7] = '{1, 0, 0, 1, 1, 0, 1};

    initial begin
        logic [NE*EW-1:0] v_base;
        v_base = vec4(8'h11, 8'h22, 8'h33, 8'h44);

        repeat (2) @(negedge clk);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic stream with ready held high.
        cycle(1'b1, v_base, 32'd4, 1'b1);
        idle(6);

        // Backpressure pattern.
        cycle(1'b1, v_base, 32'd4, 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b0, '0, 32'd0, bp[i][0]);
        idle(3);

        // Back-to-back: second vector arrives with the last transfer of the first.
        cycle(1'b1, v_base, 32'd4, 1'b1);
        idle(3);
        cycle(1'b1, vec4(8'hA0, 8'hA1, 8'h00, 8'h00), 32'd2, 1'b1);
        idle(4);

        // Single element, signed-looking value.
        cycle(1'b1, vec4(8'h80, 8'h55, 8'h66, 8'h77), 32'd1, 1'b1);
        idle(3);

        // Zero count is ignored.
        cycle(1'b1, rand_vec(), 32'd0, 1'b1);
        idle(3);

        // Clamp to capacity.
        cycle(1'b1, rand_vec(), 32'd100, 1'b1);
        idle(NE + 3);

        // Reset mid-stream after two beats.
        cycle(1'b1, v_base, 32'd4, 1'b1);
        idle(2);
        rst_n = 1'b0;
        #1;
        chk("arst_m_valid", 32'(m_valid), 32'd0);
        chk("arst_m_last", 32'(m_last), 32'd0);
        chk("arst_m_data", 32'(m_data), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_overrun", 32'(overrun), 32'd0);
        exp_q.delete();
        exp_ovr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, vec4(8'h01, 8'h02, 8'h03, 8'h04), 32'd4, 1'b1);
        idle(6);

        // Overrun: extra vector during beat 2 is dropped; overrun is sticky.
        cycle(1'b1, v_base, 32'd4, 1'b1);
        cycle(1'b0, '0, 32'd0, 1'b1);
        cycle(1'b1, rand_vec(), 32'd3, 1'b1);
        idle(6);

        // Random traffic.
        for (int n = 0; n < 500; n++) begin
            cycle(($urandom_range(0, 5) == 0), rand_vec(), 32'($urandom_range(0, 20)),
                  ($urandom_range(0, 3) != 0));
        end
        idle(NE + 4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
